sr_reg_bank: RTL and testbench

//  Parametrised, clocked bank of CHANNELS set/reset flip-flops; successor to the bare SR latch.
//  - Defined S=R=1 resolution (MODE), global enable, optional input synchroniser, edge pulses, conflict flag.
//  - Used wherever sticky status/event bits are needed: interrupt pending bits, error flags, handshake "done" bits.

---
 rtl/sr_bank_pkg.sv | 30 +++
 rtl/sr_reg_bank_cell.sv | 43 ++++
 rtl/sr_reg_bank.sv | 111 +++++++++++
 tb/tb_sr_reg_bank.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared mode encodings and next-state function for the SR register bank.
package sr_bank_pkg;

    localparam int unsigned MODE_HOLD   = 0;
    localparam int unsigned MODE_SET    = 1;
    localparam int unsigned MODE_RST    = 2;
    localparam int unsigned MODE_TOGGLE = 3;

    // Next state of one SR channel; S=R=1 is resolved by mode.
    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input int unsigned mode);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b00: nxt = q;
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            default: begin
                case (mode)
                    MODE_SET:    nxt = 1'b1;
                    MODE_RST:    nxt = 1'b0;
                    MODE_TOGGLE: nxt = ~q;
                    default:     nxt = q;
                endcase
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_reg_bank_cell.sv
// One SR channel: state flop, complement flop and edge-pulse flops.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter int unsigned MODE     = MODE_HOLD,
    parameter logic        INIT_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qn,
    output logic rise,
    output logic fall
);

    logic q_next;

    // Resolved next state for this channel.
    always_comb begin
        q_next = sr_next(q, s, r, MODE);
    end

    // State, complement and single-cycle edge pulses, all updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= INIT_VAL;
            qn   <= ~INIT_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            if (en) begin
                q  <= q_next;
                qn <= ~q_next;
            end
            rise <= en & ~q & q_next;
            fall <= en & q & ~q_next;
        end
    end

endmodule

// File: rtl/sr_reg_bank.sv
// Clocked bank of set/reset flip-flops with optional input synchroniser.
// Optional feature macro: SR_CONFLICT_CNT_EN adds cnt_clr / conflict_cnt
// (saturating count of cycles with any S&R while enabled).
module sr_reg_bank
    import sr_bank_pkg::*;
#(
    parameter int unsigned          CHANNELS    = 8,
    parameter int unsigned          MODE        = MODE_HOLD,
    parameter logic [CHANNELS-1:0]  INIT        = '0,
    parameter int unsigned          SYNC_STAGES = 0,
    parameter int unsigned          CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] S,
    input  logic [CHANNELS-1:0] R,
    output logic [CHANNELS-1:0] Q,
    output logic [CHANNELS-1:0] Qn,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                conflict
`ifdef SR_CONFLICT_CNT_EN
    ,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    conflict_cnt
`endif
);

    logic [CHANNELS-1:0] s_smp;
    logic [CHANNELS-1:0] r_smp;
    logic                conflict_now;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_smp = S;
            assign r_smp = R;
        end else begin : g_sync
            logic [CHANNELS-1:0] s_pipe [SYNC_STAGES];
            logic [CHANNELS-1:0] r_pipe [SYNC_STAGES];

            // Synchroniser chain; shifts every cycle independent of en.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                        s_pipe[k] <= '0;
                        r_pipe[k] <= '0;
                    end
                end else begin
                    s_pipe[0] <= S;
                    r_pipe[0] <= R;
                    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                        s_pipe[k] <= s_pipe[k-1];
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign s_smp = s_pipe[SYNC_STAGES-1];
            assign r_smp = r_pipe[SYNC_STAGES-1];
        end
    endgenerate

    // Independent per-channel SR cells.
    generate
        for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_cell
            sr_cell #(
                .MODE     (MODE),
                .INIT_VAL (INIT[i])
            ) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (en),
                .s    (s_smp[i]),
                .r    (r_smp[i]),
                .q    (Q[i]),
                .qn   (Qn[i]),
                .rise (rise[i]),
                .fall (fall[i])
            );
        end
    endgenerate

    // Any channel requesting set and reset together while enabled.
    always_comb begin
        conflict_now = en & (|(s_smp & r_smp));
    end

    // Registered conflict flag, one cycle per conflicting sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict <= 1'b0;
        end else begin
            conflict <= conflict_now;
        end
    end

`ifdef SR_CONFLICT_CNT_EN
    // Saturating conflict counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (cnt_clr) begin
            conflict_cnt <= '0;
        end else if (conflict_now && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: one instance per MODE plus a 2-stage synchroniser instance.
`timescale 1ns/1ps
module tb_sr_reg_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] s_in;
    logic [3:0] r_in;
    logic       cnt_clr;

    logic [3:0] q_m    [4];
    logic [3:0] qn_m   [4];
    logic [3:0] rise_m [4];
    logic [3:0] fall_m [4];
    logic       conf_m [4];
    logic [7:0] cnt_m  [4];

    logic [3:0] q_s, qn_s, rise_s, fall_s;
    logic       conf_s;
    logic [7:0] cnt_s;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instance per S=R=1 resolution mode.
    for (genvar m = 0; m < 4; m++) begin : g_mode
        sr_reg_bank #(
            .CHANNELS   (4),
            .MODE       (m),
            .INIT       (4'b0000),
            .SYNC_STAGES(0),
            .CNT_W      (8)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .S       (s_in),
            .R       (r_in),
            .Q       (q_m[m]),
            .Qn      (qn_m[m]),
            .rise    (rise_m[m]),
            .fall    (fall_m[m]),
            .conflict(conf_m[m])
`ifdef SR_CONFLICT_CNT_EN
            ,
            .cnt_clr     (cnt_clr),
            .conflict_cnt(cnt_m[m])
`endif
        );
`ifndef SR_CONFLICT_CNT_EN
        assign cnt_m[m] = 8'd0;
`endif
    end

    sr_reg_bank #(
        .CHANNELS   (4),
        .MODE       (0),
        .INIT       (4'b0000),
        .SYNC_STAGES(2),
        .CNT_W      (8)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .S       (s_in),
        .R       (r_in),
        .Q       (q_s),
        .Qn      (qn_s),
        .rise    (rise_s),
        .fall    (fall_s),
        .conflict(conf_s)
`ifdef SR_CONFLICT_CNT_EN
        ,
        .cnt_clr     (cnt_clr),
        .conflict_cnt(cnt_s)
`endif
    );
`ifndef SR_CONFLICT_CNT_EN
    assign cnt_s = 8'd0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_in  = 4'b0000;
        r_in  = 4'b0000;
        en    = 1'b1;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        s_in = 4'b1011;
        r_in = 4'b0001;
        tick();
        checks++;
        if (q_m[0] !== 4'b1010) begin
            $display("FAIL reset_setup_q: got %b expected %b", q_m[0], 4'b1010); errors++;
        end
        checks++;
        if (conf_m[0] !== 1'b1) begin
            $display("FAIL reset_setup_conflict: got %b expected 1", conf_m[0]); errors++;
        end
        s_in = 4'b0000;
        r_in = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q_m[0] !== 4'b0000 || qn_m[0] !== 4'b1111) begin
            $display("FAIL reset_q_qn: got Q=%b Qn=%b expected Q=0000 Qn=1111", q_m[0], qn_m[0]); errors++;
        end
        checks++;
        if (rise_m[0] !== 4'b0000 || fall_m[0] !== 4'b0000 || conf_m[0] !== 1'b0) begin
            $display("FAIL reset_pulses: got rise=%b fall=%b conflict=%b expected 0000 0000 0",
                     rise_m[0], fall_m[0], conf_m[0]); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_set_reset();
        do_reset();
        s_in = 4'b0001;
        tick();
        s_in = 4'b0000;
        checks++;
        if (q_m[0] !== 4'b0001 || rise_m[0] !== 4'b0001 || qn_m[0] !== 4'b1110) begin
            $display("FAIL set_edge: got Q=%b Qn=%b rise=%b expected 0001 1110 0001", q_m[0], qn_m[0], rise_m[0]); errors++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (q_m[0] !== 4'b0001 || rise_m[0] !== 4'b0000) begin
                $display("FAIL hold_after_set: cycle %0d got Q=%b rise=%b expected 0001 0000", i, q_m[0], rise_m[0]); errors++;
            end
        end
        s_in = 4'b0001;
        tick();
        s_in = 4'b0000;
        checks++;
        if (q_m[0] !== 4'b0001 || rise_m[0] !== 4'b0000) begin
            $display("FAIL set_on_one: got Q=%b rise=%b expected 0001 0000", q_m[0], rise_m[0]); errors++;
        end
        r_in = 4'b0001;
        tick();
        r_in = 4'b0000;
        checks++;
        if (q_m[0] !== 4'b0000 || fall_m[0] !== 4'b0001) begin
            $display("FAIL reset_edge: got Q=%b fall=%b expected 0000 0001", q_m[0], fall_m[0]); errors++;
        end
        tick();
        checks++;
        if (fall_m[0] !== 4'b0000) begin
            $display("FAIL fall_one_cycle: got %b expected 0000", fall_m[0]); errors++;
        end
    endtask

    task automatic test_modes();
        logic [3:0] exp_q    [4];
        logic [3:0] exp_rise [4];
        logic [3:0] exp_fall [4];
        exp_q[0] = 4'b0001; exp_rise[0] = 4'b0000; exp_fall[0] = 4'b0000;
        exp_q[1] = 4'b0011; exp_rise[1] = 4'b0010; exp_fall[1] = 4'b0000;
        exp_q[2] = 4'b0000; exp_rise[2] = 4'b0000; exp_fall[2] = 4'b0001;
        exp_q[3] = 4'b0010; exp_rise[3] = 4'b0010; exp_fall[3] = 4'b0001;
        do_reset();
        s_in = 4'b0001;
        tick();
        s_in = 4'b0011;
        r_in = 4'b0011;
        tick();
        s_in = 4'b0000;
        r_in = 4'b0000;
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_m[m] !== exp_q[m] || qn_m[m] !== ~exp_q[m]) begin
                $display("FAIL mode%0d_q: got Q=%b Qn=%b expected Q=%b", m, q_m[m], qn_m[m], exp_q[m]); errors++;
            end
            checks++;
            if (rise_m[m] !== exp_rise[m] || fall_m[m] !== exp_fall[m]) begin
                $display("FAIL mode%0d_pulses: got rise=%b fall=%b expected %b %b",
                         m, rise_m[m], fall_m[m], exp_rise[m], exp_fall[m]); errors++;
            end
            checks++;
            if (conf_m[m] !== 1'b1) begin
                $display("FAIL mode%0d_conflict: got %b expected 1", m, conf_m[m]); errors++;
            end
        end
        tick();
        checks++;
        if (conf_m[0] !== 1'b0 || q_m[3] !== 4'b0010) begin
            $display("FAIL conflict_clear: got conflict=%b Qtoggle=%b expected 0 0010", conf_m[0], q_m[3]); errors++;
        end
    endtask

    task automatic test_enable();
        do_reset();
        en   = 1'b0;
        s_in = 4'b1111;
        r_in = 4'b0001;
        tick();
        checks++;
        if (q_m[0] !== 4'b0000 || rise_m[0] !== 4'b0000 || conf_m[0] !== 1'b0) begin
            $display("FAIL en_low: got Q=%b rise=%b conflict=%b expected 0000 0000 0", q_m[0], rise_m[0], conf_m[0]); errors++;
        end
        r_in = 4'b0000;
        tick();
        checks++;
        if (q_m[0] !== 4'b0000) begin
            $display("FAIL en_low_hold: got %b expected 0000", q_m[0]); errors++;
        end
        en = 1'b1;
        tick();
        s_in = 4'b0000;
        checks++;
        if (q_m[0] !== 4'b1111 || rise_m[0] !== 4'b1111) begin
            $display("FAIL en_high: got Q=%b rise=%b expected 1111 1111", q_m[0], rise_m[0]); errors++;
        end
    endtask

    task automatic test_sync();
        do_reset();
        s_in = 4'b0100;
        tick();
        s_in = 4'b0000;
        checks++;
        if (q_s !== 4'b0000) begin
            $display("FAIL sync_edge1: got %b expected 0000", q_s); errors++;
        end
        tick();
        checks++;
        if (q_s !== 4'b0000) begin
            $display("FAIL sync_edge2: got %b expected 0000", q_s); errors++;
        end
        tick();
        checks++;
        if (q_s !== 4'b0100 || rise_s !== 4'b0100) begin
            $display("FAIL sync_edge3: got Q=%b rise=%b expected 0100 0100", q_s, rise_s); errors++;
        end
        do_reset();
        s_in = 4'b0100;
        tick();
        s_in = 4'b0000;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (q_s !== 4'b0000 || rise_s !== 4'b0000) begin
            $display("FAIL sync_flush: got Q=%b rise=%b expected 0000 0000", q_s, rise_s); errors++;
        end
    endtask

`ifdef SR_CONFLICT_CNT_EN
    task automatic test_conflict_cnt();
        do_reset();
        cnt_clr = 1'b0;
        s_in = 4'b0001;
        r_in = 4'b0001;
        tick();
        checks++;
        if (cnt_m[0] !== 8'd1) begin
            $display("FAIL cnt_first: got %0d expected 1", cnt_m[0]); errors++;
        end
        for (int i = 1; i < 300; i++) tick();
        checks++;
        if (cnt_m[0] !== 8'd255 || conf_m[0] !== 1'b1) begin
            $display("FAIL cnt_saturate: got cnt=%0d conflict=%b expected 255 1", cnt_m[0], conf_m[0]); errors++;
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (cnt_m[0] !== 8'd0) begin
            $display("FAIL cnt_clear_wins: got %0d expected 0", cnt_m[0]); errors++;
        end
        tick();
        s_in = 4'b0000;
        r_in = 4'b0000;
        checks++;
        if (cnt_m[0] !== 8'd1) begin
            $display("FAIL cnt_after_clear: got %0d expected 1", cnt_m[0]); errors++;
        end
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        s_in    = 4'b0000;
        r_in    = 4'b0000;
        cnt_clr = 1'b0;
        test_reset();
        test_set_reset();
        test_modes();
        test_enable();
        test_sync();
`ifdef SR_CONFLICT_CNT_EN
        test_conflict_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
